// File: rtl/sram_hs_ctrl.sv
// rtl/sram_hs_ctrl.sv - single-port async SRAM controller with wait states, byte lanes and setup/hold sequencing
//
// Purpose:
//   Accepts one read or write request at a time over a valid/ready channel.
//   It then runs the SRAM access sequence IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> HOLD -> IDLE.
//   Every SRAM strobe and the bus-drive enable come straight from registers.
//   Read data is captured on the edge that ends ACCESS and presented with a one-cycle rsp_valid_o pulse.
//
// Optional feature (macro SRAM_HS_TURN_EN):
//   When defined, a one-cycle TURN state with all strobes deasserted is inserted before ACCESS
//   whenever the access direction differs from the previous access. The direction record resets to read.
//
// Ports:
//   clk, rst_n       clock; synchronous active-low reset
//   req_valid_i      request present
//   req_ready_o      high while idle; a request is accepted on an edge with req_valid_i && req_ready_o
//   req_we_i         1 = write, 0 = read
//   req_addr_i       word address
//   req_wdata_i      write data
//   req_be_i         byte enables, active-high
//   rsp_valid_o      one-cycle pulse, rsp_rdata_o valid
//   rsp_rdata_o      read data, held until the next read completes
//   busy_o           controller not idle
//   sram_data_io     bidirectional SRAM data bus
//   sram_addr_o      registered SRAM address
//   sram_ce_n_o      chip enable, active-low
//   sram_oe_n_o      output enable, active-low
//   sram_we_n_o      write enable, active-low
//   sram_be_n_o      byte-lane enables, active-low

`timescale 1ns/1ps

module sram_hs_ctrl #(
  parameter int  DW          = 16,
  parameter int  AW          = 19,
  parameter int  WAIT_CYCLES = 1,
  localparam int NB          = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  input  logic [NB-1:0] req_be_i,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rsp_rdata_o,
  output logic          busy_o,
  inout  wire  [DW-1:0] sram_data_io,
  output logic [AW-1:0] sram_addr_o,
  output logic          sram_ce_n_o,
  output logic          sram_oe_n_o,
  output logic          sram_we_n_o,
  output logic [NB-1:0] sram_be_n_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TURN   = 2'd1,
    S_ACCESS = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic [NB-1:0] be_q;
  logic          drive_q;
  logic          ce_n_q;
  logic          oe_n_q;
  logic          we_n_q;
  logic [NB-1:0] be_n_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_rdata_q;

  logic          accept_d;
  logic          turn_d;
  logic          start_d;
  logic          acc_we_d;
  logic [NB-1:0] acc_be_d;

`ifdef SRAM_HS_TURN_EN
  // Direction of the most recent accepted access; 0 = read.
  logic dir_q;
  assign turn_d = (req_we_i != dir_q);
`else
  assign turn_d = 1'b0;
`endif

  // ACCESS is entered either directly from an accepted request or from TURN,
  // in which case the latched copies of the request fields are used.
  always_comb begin
    accept_d = (state_q == S_IDLE) && req_valid_i;
    start_d  = (accept_d && !turn_d) || (state_q == S_TURN);
    acc_we_d = (state_q == S_IDLE) ? req_we_i : we_q;
    acc_be_d = (state_q == S_IDLE) ? req_be_i : be_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      drive_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= '1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef SRAM_HS_TURN_EN
      dir_q       <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;

      if (accept_d) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        we_q    <= req_we_i;
        be_q    <= req_be_i;
`ifdef SRAM_HS_TURN_EN
        dir_q   <= req_we_i;
`endif
        if (turn_d) begin
          state_q <= S_TURN;
        end
      end

      if (start_d) begin
        state_q <= S_ACCESS;
        cnt_q   <= CNT_INIT;
        ce_n_q  <= 1'b0;
        we_n_q  <= ~acc_we_d;
        oe_n_q  <= acc_we_d;
        be_n_q  <= ~acc_be_d;
        drive_q <= acc_we_d;
      end

      case (state_q)
        S_ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_HOLD;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            if (!we_q) begin
              rsp_rdata_q <= sram_data_io;
              rsp_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_HOLD: begin
          // Write data remains driven through HOLD for data hold time.
          state_q <= S_IDLE;
          ce_n_q  <= 1'b1;
          be_n_q  <= '1;
          drive_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign sram_data_io = drive_q ? wdata_q : {DW{1'bz}};

  assign req_ready_o  = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign sram_addr_o  = addr_q;
  assign sram_ce_n_o  = ce_n_q;
  assign sram_oe_n_o  = oe_n_q;
  assign sram_we_n_o  = we_n_q;
  assign sram_be_n_o  = be_n_q;

endmodule

// File: tb/tb_sram_hs_ctrl.sv
// tb/tb_sram_hs_ctrl.sv - self-checking bench for sram_hs_ctrl with an SRAM pin model and a word-level reference memory

`timescale 1ns/1ps

module tb_sram_hs_ctrl;

  localparam int W  = 1;
  localparam int DW = 16;
  localparam int AW = 19;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [1:0]    req_be;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  wire  [DW-1:0] sram_data;
  logic [AW-1:0] sram_addr;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic [1:0]    sram_be_n;

  int n_checks = 0;
  int n_fail   = 0;

  sram_hs_ctrl #(.DW(DW), .AW(AW), .WAIT_CYCLES(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_be_i     (req_be),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .busy_o       (busy),
    .sram_data_io (sram_data),
    .sram_addr_o  (sram_addr),
    .sram_ce_n_o  (sram_ce_n),
    .sram_oe_n_o  (sram_oe_n),
    .sram_we_n_o  (sram_we_n),
    .sram_be_n_o  (sram_be_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Async SRAM pin model: drives the bus while selected with output enabled,
  // and writes enabled byte lanes on each clock edge seen with we_n low.
  logic [DW-1:0] sram_mem [logic [AW-1:0]];
  logic [DW-1:0] rd_val = '0;

  assign sram_data = (!sram_ce_n && !sram_oe_n) ? rd_val : {DW{1'bz}};

  always @(negedge clk) begin
    rd_val = sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : '0;
  end

  always @(posedge clk) begin
    logic [DW-1:0] tmp;
    if (!sram_ce_n && !sram_we_n) begin
      tmp = sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : '0;
      for (int i = 0; i < 2; i++)
        if (!sram_be_n[i]) tmp[8*i +: 8] = sram_data[8*i +: 8];
      sram_mem[sram_addr] = tmp;
    end
  end

  // Reference memory updated from issued requests, independent of the pins.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  bit            last_dir = 1'b0;
  bit            run_inv  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_inv) check("we_oe_overlap", {31'd0, (!sram_we_n && !sram_oe_n)}, 32'd0);
  end

  // Issue one request from a negedge with the controller idle, then check every
  // cycle of its sequence. Returns at the negedge where the controller is idle again,
  // with req_valid still high so the next call goes back-to-back.
  task automatic txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] b);
    int            t;
    int            ph;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] old;
    check("ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = b;
    t = 0;
`ifdef SRAM_HS_TURN_EN
    t = (we != last_dir) ? 1 : 0;
`endif
    last_dir = we;
    old = ref_mem.exists(a) ? ref_mem[a] : '0;
    exp_rd = old;
    if (we) begin
      for (int i = 0; i < 2; i++)
        if (b[i]) old[8*i +: 8] = d[8*i +: 8];
      ref_mem[a] = old;
    end
    @(posedge clk);
    #1;
    // Request fields are don't-care while the controller is busy.
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
    req_be    = 2'($urandom);
    req_we    = 1'($urandom);
    for (int j = 0; j <= W + 2 + t; j++) begin
      @(negedge clk);
      ph = j - t;
      if (ph < 0) begin
        check("turn_ce_n", {31'd0, sram_ce_n}, 32'd1);
        check("turn_we_n", {31'd0, sram_we_n}, 32'd1);
        check("turn_oe_n", {31'd0, sram_oe_n}, 32'd1);
        check("turn_ready", {31'd0, req_ready}, 32'd0);
      end else if (ph <= W) begin
        check("acc_ce_n", {31'd0, sram_ce_n}, 32'd0);
        check("acc_we_n", {31'd0, sram_we_n}, {31'd0, !we});
        check("acc_oe_n", {31'd0, sram_oe_n}, {31'd0, we});
        check("acc_be_n", {30'd0, sram_be_n}, {30'd0, ~b});
        check("acc_addr", {13'd0, sram_addr}, {13'd0, a});
        check("acc_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("acc_ready", {31'd0, req_ready}, 32'd0);
        check("acc_busy", {31'd0, busy}, 32'd1);
        if (we) check("acc_wbus", {16'd0, sram_data}, {16'd0, d});
      end else if (ph == W + 1) begin
        check("hold_ce_n", {31'd0, sram_ce_n}, 32'd0);
        check("hold_we_n", {31'd0, sram_we_n}, 32'd1);
        check("hold_oe_n", {31'd0, sram_oe_n}, 32'd1);
        check("hold_ready", {31'd0, req_ready}, 32'd0);
        check("hold_rsp_valid", {31'd0, rsp_valid}, {31'd0, !we});
        if (we) check("hold_wbus", {16'd0, sram_data}, {16'd0, d});
        else    check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, exp_rd});
      end else begin
        check("idle_ce_n", {31'd0, sram_ce_n}, 32'd1);
        check("idle_we_n", {31'd0, sram_we_n}, 32'd1);
        check("idle_oe_n", {31'd0, sram_oe_n}, 32'd1);
        check("idle_be_n", {30'd0, sram_be_n}, 32'd3);
        check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("idle_ready", {31'd0, req_ready}, 32'd1);
        if (!we) check("rdata_held", {16'd0, rsp_rdata}, {16'd0, exp_rd});
      end
    end
  endtask

  task automatic gap();
    req_valid = 1'b0;
    @(negedge clk);
    check("gap_no_accept", {31'd0, busy}, 32'd0);
  endtask

  logic [AW-1:0] addr_pool [5];

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 19'h00042;
    req_wdata = 16'h1234;
    req_be    = 2'b11;

    // Reset held 3 cycles with a pending request.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
      check("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
      check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
      check("rst_be_n", {30'd0, sram_be_n}, 32'd3);
      check("rst_addr", {13'd0, sram_addr}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    end
    req_valid = 1'b0;
    rst_n     = 1'b1;
    run_inv   = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    // Write then read back full word.
    txn(1'b1, 19'h12345, 16'hBEEF, 2'b11);
    txn(1'b0, 19'h12345, 16'h0000, 2'b11);
    gap();

    // Byte-lane merge.
    txn(1'b1, 19'h00777, 16'hAA55, 2'b01);
    txn(1'b1, 19'h00777, 16'h1200, 2'b10);
    txn(1'b0, 19'h00777, 16'h0000, 2'b11);
    check("bytelane_merge", {16'd0, rsp_rdata}, 32'h1255);
    gap();

    // Back-to-back reads with valid held high, including a no-lane read and max address.
    txn(1'b1, 19'h7FFFF, 16'hC0DE, 2'b11);
    txn(1'b0, 19'h7FFFF, 16'h0000, 2'b11);
    txn(1'b0, 19'h12345, 16'h0000, 2'b00);
    txn(1'b0, 19'h00777, 16'h0000, 2'b11);
    gap();

    // Reset during the second ACCESS cycle of a read.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 19'h12345;
    req_be    = 2'b11;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_acc_oe_n", {31'd0, sram_oe_n}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ce_n", {31'd0, sram_ce_n}, 32'd1);
    check("abort_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    rst_n    = 1'b1;
    last_dir = 1'b0;
    @(negedge clk);
    check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    txn(1'b1, 19'h00100, 16'h5A5A, 2'b11);
    txn(1'b0, 19'h00100, 16'h0000, 2'b11);
    gap();

    // Randomized traffic over a small address pool.
    addr_pool[0] = 19'h00000;
    addr_pool[1] = 19'h00001;
    addr_pool[2] = 19'h12345;
    addr_pool[3] = 19'h7FFFF;
    addr_pool[4] = 19'h3C3C3;
    for (int n = 0; n < 60; n++) begin
      txn(1'($urandom), addr_pool[$urandom_range(0, 4)], DW'($urandom), 2'($urandom));
      if ($urandom_range(0, 3) == 0) gap();
    end
    gap();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
